// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg: default geometry and output FSM state type shared by the PISO stage.
package piso_stream_pkg;
    localparam int PE_NUM_DEF = 8;
    localparam int DATA_WIDTH_DEF = 16;
    typedef enum logic {IDLE, STREAM} out_state_e;
endpackage

// File: rtl/piso_stream_slot.sv
// piso_slot: one PE_NUM-word register bank with a parallel load and a lane-select read port.
module piso_slot
    import piso_stream_pkg::*;
#(
    parameter int PE_NUM = PE_NUM_DEF,
    parameter int WORD_W = 2 * DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        load_i,
    input  logic [PE_NUM*WORD_W-1:0]    data_i,
    input  logic [$clog2(PE_NUM)-1:0]   sel_i,
    output logic [WORD_W-1:0]           word_o
);
    logic [PE_NUM-1:0][WORD_W-1:0] bank_q;

    always_ff @(posedge clk) begin
        if (load_i) bank_q <= data_i;
    end

    assign word_o = bank_q[sel_i];
endmodule

// File: rtl/piso_stream.sv
// piso_stream: ping-pong buffered parallel-in/serial-out stage, one complex word per cycle.
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int PE_NUM     = PE_NUM_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             p_in_v,
    output logic                             p_in_rdy,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]   p_in,
    output logic                             s_out_v,
    input  logic                             s_out_rdy,
    output logic [2*DATA_WIDTH-1:0]          s_out,
    output logic                             s_out_last
);
    localparam int WW = 2 * DATA_WIDTH;
    localparam int LW = $clog2(PE_NUM);
    localparam logic [LW-1:0] LAST = LW'(PE_NUM - 1);

    out_state_e          state_q;
    logic [1:0]          full_q;
    logic                wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       lane_q, lane_d, rd_sel;
    logic [WW-1:0]       s_out_q;
    logic                s_out_v_q, s_out_last_q;
    logic [1:0][WW-1:0]  word;
    logic                accept, advance, release_slot, load, slot_d;

    for (genvar k = 0; k < 2; k++) begin : g_slot
        piso_slot #(.PE_NUM(PE_NUM), .WORD_W(WW)) u_slot (
            .clk    (clk),
            .load_i (accept && wr_ptr_q == 1'(k)),
            .data_i (p_in),
            .sel_i  (rd_sel),
            .word_o (word[k])
        );
    end

    // The word for the next output register is chosen one cycle ahead: either the
    // following lane of the current slot or the first lane of the other slot.
    always_comb begin
        p_in_rdy     = !full_q[wr_ptr_q];
        accept       = p_in_v && p_in_rdy;
        advance      = (state_q == STREAM) && s_out_rdy;
        release_slot = advance && (lane_q == LAST);
        slot_d       = release_slot ? !rd_ptr_q : rd_ptr_q;
        lane_d       = (advance && !release_slot) ? lane_q + 1'b1 : '0;
        load         = advance ? (!release_slot || full_q[!rd_ptr_q])
                               : (state_q == IDLE && full_q[rd_ptr_q]);
        rd_sel       = LSB_FIRST ? lane_d : LAST - lane_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            full_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            lane_q       <= '0;
            s_out_q      <= '0;
            s_out_v_q    <= 1'b0;
            s_out_last_q <= 1'b0;
        end else begin
            if (accept) begin
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (release_slot) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= !rd_ptr_q;
            end
            if (load) begin
                state_q      <= STREAM;
                lane_q       <= lane_d;
                s_out_q      <= word[slot_d];
                s_out_v_q    <= 1'b1;
                s_out_last_q <= (lane_d == LAST);
            end else if (advance) begin
                state_q      <= IDLE;
                lane_q       <= '0;
                s_out_v_q    <= 1'b0;
                s_out_last_q <= 1'b0;
            end
        end
    end

    assign s_out      = s_out_q;
    assign s_out_v    = s_out_v_q;
    assign s_out_last = s_out_last_q;
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: queue-based model check of both lane orders plus directed literal checks.
module tb_piso_stream;
    typedef logic [127:0] vec_t;

    logic        clk = 1'b0;
    logic        rst, p_in_v, s_out_rdy;
    vec_t        p_in;
    logic        p_in_rdy, s_out_v, s_out_last;
    logic [31:0] s_out;
    logic        p_in_rdy_r, s_out_v_r, s_out_last_r;
    logic [31:0] s_out_r;

    int vectors = 0, fails = 0;
    int mode = 0, cyc = 0, edge_n = 0, lane_m = 0, acc_cnt = 0, last_cnt = 0;
    vec_t mq[$];
    int   me[$];
    logic [31:0] log_q[$], log_r[$];
    logic        log_l[$];
    int          log_t[$];
    logic        ev;

    piso_stream #(.PE_NUM(4), .DATA_WIDTH(16), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .p_in_v(p_in_v), .p_in_rdy(p_in_rdy), .p_in(p_in),
        .s_out_v(s_out_v), .s_out_rdy(s_out_rdy), .s_out(s_out), .s_out_last(s_out_last)
    );

    piso_stream #(.PE_NUM(4), .DATA_WIDTH(16), .LSB_FIRST(1'b0)) dut_r (
        .clk(clk), .rst(rst), .p_in_v(p_in_v), .p_in_rdy(p_in_rdy_r), .p_in(p_in),
        .s_out_v(s_out_v_r), .s_out_rdy(s_out_rdy), .s_out(s_out_r), .s_out_last(s_out_last_r)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane_of(input vec_t v, input int j);
        return v[j*32 +: 32];
    endfunction

    function automatic vec_t mk(input logic [31:0] base);
        vec_t v;
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = base + 32'(j);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a vector is visible from the edge after its accept once all older vectors are gone.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            me.delete();
            lane_m = 0;
        end else begin
            automatic bit acc = p_in_v && (mq.size() < 2);
            automatic bit hs  = s_out_rdy && mq.size() > 0 && me[0] < edge_n;
            if (hs) begin
                lane_m++;
                if (lane_m == 4) begin
                    lane_m = 0;
                    void'(mq.pop_front());
                    void'(me.pop_front());
                end
            end
            if (acc) begin
                mq.push_back(p_in);
                me.push_back(edge_n + 1);
                acc_cnt++;
            end
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            ev = mq.size() > 0 && me[0] < edge_n;
            chk("p_in_rdy", 32'(p_in_rdy), 32'(mq.size() < 2));
            chk("p_in_rdy_r", 32'(p_in_rdy_r), 32'(mq.size() < 2));
            chk("s_out_v", 32'(s_out_v), 32'(ev));
            chk("s_out_v_r", 32'(s_out_v_r), 32'(ev));
            if (ev) begin
                chk("s_out", s_out, lane_of(mq[0], lane_m));
                chk("s_out_r", s_out_r, lane_of(mq[0], 3 - lane_m));
                chk("s_out_last", 32'(s_out_last), 32'(lane_m == 3));
                chk("s_out_last_r", 32'(s_out_last_r), 32'(lane_m == 3));
                if (s_out_rdy) begin
                    log_q.push_back(s_out);
                    log_r.push_back(s_out_r);
                    log_l.push_back(s_out_last);
                    log_t.push_back(edge_n);
                    if (s_out_last) last_cnt++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        s_out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end

    task automatic clear_log();
        log_q.delete();
        log_r.delete();
        log_l.delete();
        log_t.delete();
    endtask

    task automatic send_vec(input vec_t v);
        automatic int k = 0;
        automatic logic ok;
        p_in = v;
        p_in_v = 1'b1;
        do begin
            @(negedge clk) ok = p_in_rdy;
            @(posedge clk);
            k++;
        end while (!ok && k < 100);
        if (!ok) chk("send_timeout", 0, 1);
        #2;
        p_in_v = 1'b0;
    endtask

    task automatic wait_log(input int n, input string nm);
        automatic int k = 0;
        while (log_q.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk(nm, 32'(log_q.size() >= n), 1);
    endtask

    initial begin
        rst = 1'b1;
        p_in_v = 1'b0;
        p_in = '0;
        s_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(p_in_rdy), 1);
        chk("rst_v", 32'(s_out_v), 0);
        chk("rst_dout", s_out, 0);
        chk("rst_last", 32'(s_out_last), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;

        // single vector, latency and both lane orders
        clear_log();
        send_vec(mk(32'hA000_0000));
        @(negedge clk);
        chk("lat_v0", 32'(s_out_v), 0);
        @(negedge clk);
        chk("lat_v1", 32'(s_out_v), 1);
        chk("first_word", s_out, 32'hA000_0000);
        chk("first_word_r", s_out_r, 32'hA000_0003);
        wait_log(4, "t1_words");
        @(negedge clk);
        chk("idle_after", 32'(s_out_v), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_seq", log_q[i], 32'hA000_0000 + 32'(i));
            chk("t4_seq", log_r[i], 32'hA000_0003 - 32'(i));
            chk("t1_last", 32'(log_l[i]), 32'(i == 3));
        end

        // back-to-back vectors, no bubble
        @(posedge clk);
        #2;
        clear_log();
        send_vec(mk(32'hC000_0000));
        send_vec(mk(32'hC000_0010));
        @(negedge clk);
        chk("both_full_rdy", 32'(p_in_rdy), 0);
        @(posedge clk);
        #2;
        send_vec(mk(32'hC000_0020));
        wait_log(12, "t2_words");
        for (int i = 0; i < 12; i++) chk("t2_seq", log_q[i], 32'hC000_0000 + 32'((i / 4) * 16 + i % 4));
        chk("t2_contig", 32'(log_t[11] - log_t[0]), 11);

        // backpressure 1,0,0,1,...
        repeat (3) @(posedge clk);
        #2;
        mode = 1;
        clear_log();
        send_vec(mk(32'hA000_0000));
        send_vec(mk(32'hA000_0000));
        @(negedge clk);
        chk("bp_full_rdy", 32'(p_in_rdy), 0);
        wait_log(8, "t3_words");
        for (int i = 0; i < 8; i++) chk("t3_seq", log_q[i], 32'hA000_0000 + 32'(i % 4));
        mode = 0;

        // reset mid-vector with a second vector buffered
        repeat (12) @(posedge clk);
        #2;
        clear_log();
        send_vec(mk(32'hA000_0000));
        send_vec(mk(32'hA000_0000));
        wait_log(2, "t5_two");
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_v", 32'(s_out_v), 0);
        chk("rst_mid_v_r", 32'(s_out_v_r), 0);
        chk("rst_mid_rdy", 32'(p_in_rdy), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        clear_log();
        send_vec(mk(32'hB000_0000));
        wait_log(4, "t5_words");
        for (int i = 0; i < 4; i++) chk("t5_seq", log_q[i], 32'hB000_0000 + 32'(i));

        // random traffic against the model
        repeat (6) @(posedge clk);
        #2;
        acc_cnt = 0;
        last_cnt = 0;
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            p_in_v = 1'($urandom_range(0, 1));
            for (int j = 0; j < 4; j++) p_in[j*32 +: 32] = $urandom;
            @(posedge clk);
            #2;
        end
        p_in_v = 1'b0;
        mode = 0;
        for (int k = 0; k < 100 && mq.size() > 0; k++) @(posedge clk);
        chk("drain", 32'(mq.size()), 0);
        repeat (2) @(posedge clk);
        chk("last_count", 32'(last_cnt), 32'(acc_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
